// File: rtl/edp_muldiv_seq.sv
// Multiply/divide step sequencer for the EBOX data path: owns AD/ADB/AR/ARX/MQ controls while busy.
// Optional macro EDP_DIVCHK_EN enables the first-step divide overflow check (divOvf).
module edp_muldiv_seq #(
    parameter int STEPW = 6
) (
    input  logic             eboxClk,
    input  logic             eboxReset_n,
    input  logic             start,
    input  logic             opDiv,
    input  logic [STEPW-1:0] stepCount,
    input  logic             abort,
    input  logic             mq35,
    input  logic             adSign,
    output logic             busy,
    output logic             done,
    output logic             divOvf,
    output logic [STEPW-1:0] stepsDone,
    output logic [6:0]       ctlAD,
    output logic [1:0]       ctlADB,
    output logic [2:0]       ctlArSel,
    output logic             ctlArLoad,
    output logic             ctlArxLoad,
    output logic [1:0]       ctlMqSel,
    output logic [1:0]       ctlMqmSel,
    output logic             ctlMqmEn,
    output logic             ctlADlong
);

    typedef enum logic [1:0] {IDLE, STEP, FIXUP, DONE} state_t;

    localparam logic [6:0]       AD_A     = 7'o37;
    localparam logic [6:0]       AD_AMB   = 7'o51;
    localparam logic [6:0]       AD_APB   = 7'o06;
    localparam logic [STEPW-1:0] STEP_ONE = {{(STEPW-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic             op_div, prev, qbit, first;
    logic [STEPW-1:0] step_cnt, steps_done, steps_inc;
    logic             last_step, ovf_hit;

    assign steps_inc = steps_done + STEP_ONE;
    assign last_step = (steps_inc == step_cnt);
    assign stepsDone = steps_done;

`ifdef EDP_DIVCHK_EN
    // No borrow on the first trial subtract means the quotient cannot fit.
    assign ovf_hit = op_div & first & ~adSign;
`else
    assign ovf_hit = 1'b0;
`endif

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        ctlAD      = AD_A;
        ctlADB     = 2'b10;
        ctlArSel   = 3'b010;
        ctlArLoad  = 1'b0;
        ctlArxLoad = 1'b0;
        ctlMqSel   = 2'b11;
        ctlMqmSel  = 2'b00;
        ctlMqmEn   = 1'b0;
        ctlADlong  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (stepCount == '0) ? DONE : STEP;
            end
            STEP: begin
                busy      = 1'b1;
                ctlArLoad = 1'b1;
                ctlMqmEn  = 1'b1;
                ctlADlong = 1'b1;
                if (op_div) begin
                    ctlAD     = (first | qbit) ? AD_AMB : AD_APB;
                    ctlMqSel  = 2'b01;
                    ctlMqmSel = 2'b01;
                    if (ovf_hit)        state_nxt = DONE;
                    else if (last_step) state_nxt = FIXUP;
                end else begin
                    case ({mq35, prev})
                        2'b10:   ctlAD = AD_AMB;
                        2'b01:   ctlAD = AD_APB;
                        default: ctlAD = AD_A;
                    endcase
                    ctlArxLoad = 1'b1;
                    ctlMqSel   = 2'b10;
                    ctlMqmSel  = 2'b10;
                    if (last_step) state_nxt = DONE;
                end
            end
            FIXUP: begin
                busy = 1'b1;
                // A final negative partial remainder is restored by adding the divisor back.
                if (!qbit) begin
                    ctlAD     = AD_APB;
                    ctlArLoad = 1'b1;
                end
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
            done      = 1'b0;
        end
    end

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            op_div     <= 1'b0;
            step_cnt   <= '0;
            steps_done <= '0;
            prev       <= 1'b0;
            qbit       <= 1'b0;
            first      <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                op_div     <= opDiv;
                step_cnt   <= stepCount;
                steps_done <= '0;
                prev       <= 1'b0;
                qbit       <= 1'b0;
                first      <= 1'b1;
            end
        end else if (state == STEP && !abort) begin
            if (steps_done != step_cnt) steps_done <= steps_inc;
            if (op_div) begin
                qbit  <= ~adSign;
                first <= 1'b0;
            end else begin
                prev <= mq35;
            end
        end
    end

`ifdef EDP_DIVCHK_EN
    logic div_ovf;
    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            div_ovf <= 1'b0;
        end else if (state == IDLE) begin
            if (start) div_ovf <= 1'b0;
        end else if (abort) begin
            div_ovf <= 1'b0;
        end else if (state == STEP && ovf_hit) begin
            div_ovf <= 1'b1;
        end
    end
    assign divOvf = div_ovf;
`else
    assign divOvf = 1'b0;
`endif

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Scoreboard bench for edp_muldiv_seq: expected per-cycle controls queued at stimulus time, popped while busy.
module tb_edp_muldiv_seq;

    localparam int STEPW = 6;

    logic             eboxClk = 1'b0;
    logic             eboxReset_n = 1'b0;
    logic             start = 1'b0, opDiv = 1'b0, abort = 1'b0, mq35 = 1'b0, adSign = 1'b0;
    logic [STEPW-1:0] stepCount = '0;
    logic             busy, done, divOvf, ctlArLoad, ctlArxLoad, ctlMqmEn, ctlADlong;
    logic [STEPW-1:0] stepsDone;
    logic [6:0]       ctlAD;
    logic [1:0]       ctlADB, ctlMqSel, ctlMqmSel;
    logic [2:0]       ctlArSel;

    typedef struct packed {
        logic [6:0] ad;
        logic       ld;
        logic [1:0] mq;
    } exp_t;

    exp_t q_exp[$];
    int   n_chk = 0;
    int   n_fail = 0;

    edp_muldiv_seq #(.STEPW(STEPW)) dut (
        .eboxClk(eboxClk), .eboxReset_n(eboxReset_n), .start(start), .opDiv(opDiv),
        .stepCount(stepCount), .abort(abort), .mq35(mq35), .adSign(adSign),
        .busy(busy), .done(done), .divOvf(divOvf), .stepsDone(stepsDone),
        .ctlAD(ctlAD), .ctlADB(ctlADB), .ctlArSel(ctlArSel), .ctlArLoad(ctlArLoad),
        .ctlArxLoad(ctlArxLoad), .ctlMqSel(ctlMqSel), .ctlMqmSel(ctlMqmSel),
        .ctlMqmEn(ctlMqmEn), .ctlADlong(ctlADlong)
    );

    always #5 eboxClk = ~eboxClk;

    task automatic tick();
        @(posedge eboxClk);
        #1;
    endtask

    // Cycle 0: present the request, confirm idle, then advance into cycle 1.
    task automatic start_op(input logic div, input int n);
        start = 1'b1; opDiv = div; stepCount = n[STEPW-1:0];
        @(negedge eboxClk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL start_idle busy=%b required 0", busy);
        end
        tick();
        start = 1'b0;
    endtask

    // Queue expectations from the operation's arithmetic rules.
    task automatic push_model(input logic div, input int n, input logic [63:0] bits,
                              output int done_cyc, output int steps, output logic ovf);
        logic p, q, f;
        p = 1'b0; q = 1'b0; f = 1'b1; ovf = 1'b0; steps = n;
        done_cyc = div ? n + 2 : n + 1;
        if (n == 0) done_cyc = 1;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            if (!div) begin
                e.ad = ({bits[i], p} == 2'b10) ? 7'o51 : ({bits[i], p} == 2'b01) ? 7'o06 : 7'o37;
                e.ld = 1'b1; e.mq = 2'b10; p = bits[i];
                q_exp.push_back(e);
            end else begin
                e.ad = (f | q) ? 7'o51 : 7'o06; e.ld = 1'b1; e.mq = 2'b01;
                q_exp.push_back(e);
`ifdef EDP_DIVCHK_EN
                if (f && !bits[i]) begin
                    ovf = 1'b1; steps = 1; done_cyc = 2;
                    break;
                end
`endif
                q = ~bits[i]; f = 1'b0;
            end
        end
        if (div && n > 0 && !ovf) begin
            exp_t e;
            e.ad = q ? 7'o37 : 7'o06; e.ld = ~q; e.mq = 2'b11;
            q_exp.push_back(e);
        end
    endtask

    // Runs from cycle 1, feeding bits[c-1] to mq35/adSign, popping one entry per busy cycle.
    task automatic run_op(input string name, input logic [63:0] bits, input int exp_done,
                          input int exp_steps, input logic exp_ovf);
        bit seen;
        seen = 1'b0;
        for (int c = 1; c <= 80 && !seen; c++) begin
            mq35 = bits[c-1]; adSign = bits[c-1];
            @(negedge eboxClk);
            if (done) begin
                seen = 1'b1;
                n_chk++;
                if (c != exp_done || stepsDone !== exp_steps[STEPW-1:0] || divOvf !== exp_ovf || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_done cycle=%0d steps=%0d ovf=%b busy=%b required cycle=%0d steps=%0d ovf=%b busy=1",
                             name, c, stepsDone, divOvf, busy, exp_done, exp_steps, exp_ovf);
                end
            end else if (busy) begin
                exp_t e;
                n_chk++;
                if (q_exp.size() == 0) begin
                    n_fail++; $display("FAIL %s_extra cycle=%0d ctlAD=%o no step expected", name, c, ctlAD);
                end else begin
                    e = q_exp.pop_front();
                    if (ctlAD !== e.ad || ctlArLoad !== e.ld || ctlMqSel !== e.mq) begin
                        n_fail++;
                        $display("FAIL %s_step cycle=%0d ctlAD=%o ld=%b mq=%b required ctlAD=%o ld=%b mq=%b",
                                 name, c, ctlAD, ctlArLoad, ctlMqSel, e.ad, e.ld, e.mq);
                    end
                end
            end else begin
                n_chk++; n_fail++;
                $display("FAIL %s_idle cycle=%0d busy=0 before done", name, c);
                seen = 1'b1;
            end
            tick();
        end
        n_chk++;
        if (!seen) begin
            n_fail++; $display("FAIL %s_timeout done never seen", name);
        end
        n_chk++;
        if (q_exp.size() != 0) begin
            n_fail++; $display("FAIL %s_leftover %0d entries required 0", name, q_exp.size());
            q_exp.delete();
        end
        @(negedge eboxClk);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || stepsDone !== exp_steps[STEPW-1:0] || ctlAD !== 7'o37) begin
            n_fail++;
            $display("FAIL %s_after busy=%b done=%b steps=%0d ctlAD=%o required 0 0 %0d 37",
                     name, busy, done, stepsDone, ctlAD, exp_steps);
        end
        tick();
    endtask

    task automatic test_reset();
        #3;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || divOvf !== 1'b0 || stepsDone !== '0 || ctlAD !== 7'o37 ||
            ctlADB !== 2'b10 || ctlArSel !== 3'b010 || ctlArLoad !== 1'b0 || ctlArxLoad !== 1'b0 ||
            ctlMqSel !== 2'b11 || ctlMqmSel !== 2'b00 || ctlMqmEn !== 1'b0 || ctlADlong !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state busy=%b done=%b ovf=%b steps=%0d ad=%o adb=%b arsel=%b mq=%b required idle values",
                     busy, done, divOvf, stepsDone, ctlAD, ctlADB, ctlArSel, ctlMqSel);
        end
        @(negedge eboxClk);
        eboxReset_n = 1'b1;
        tick();
    endtask

    task automatic test_mul_booth();
        exp_t e;
        e.ld = 1'b1; e.mq = 2'b10;
        e.ad = 7'o51; q_exp.push_back(e);
        e.ad = 7'o37; q_exp.push_back(e);
        e.ad = 7'o06; q_exp.push_back(e);
        e.ad = 7'o51; q_exp.push_back(e);
        start_op(1'b0, 4);
        run_op("mul4", 64'b1011, 5, 4, 1'b0);
    endtask

    task automatic test_div_fixup();
        exp_t e;
        e.ld = 1'b1; e.mq = 2'b01;
        e.ad = 7'o51; q_exp.push_back(e);
        e.ad = 7'o06; q_exp.push_back(e);
        e.ad = 7'o51; q_exp.push_back(e);
        e.ad = 7'o06; e.mq = 2'b11; q_exp.push_back(e);
        start_op(1'b1, 3);
        run_op("div3", 64'b101, 5, 3, 1'b0);
    endtask

    task automatic test_zero_steps();
        start_op(1'b0, 0);
        run_op("mul0", 64'd0, 1, 0, 1'b0);
        start_op(1'b1, 0);
        run_op("div0", 64'd0, 1, 0, 1'b0);
    endtask

    task automatic test_random_mul();
        logic [63:0] bits;
        int dc, st;
        logic ov;
        for (int k = 0; k < 3; k++) begin
            bits = {$urandom(), $urandom()};
            push_model(1'b0, 10 + k * 7, bits, dc, st, ov);
            start_op(1'b0, 10 + k * 7);
            run_op("mulrnd", bits, dc, st, ov);
        end
        bits = {$urandom(), $urandom()};
        bits[0] = 1'b1;
        push_model(1'b1, 12, bits, dc, st, ov);
        start_op(1'b1, 12);
        run_op("divrnd", bits, dc, st, ov);
    endtask

    task automatic test_div_overflow();
        int dc, st;
        logic ov;
        push_model(1'b1, 35, 64'd0, dc, st, ov);
        start_op(1'b1, 35);
        run_op("divchk", 64'd0, dc, st, ov);
    endtask

    task automatic test_abort();
        start_op(1'b0, 8);
        @(negedge eboxClk);
        tick();
        abort = 1'b1;
        @(negedge eboxClk);
        n_chk++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_cycle2 busy=%b done=%b required 1 0", busy, done);
        end
        tick();
        abort = 1'b0; start = 1'b1; stepCount = 6'd1; opDiv = 1'b0;
        @(negedge eboxClk);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_cycle3 busy=%b done=%b required 0 0", busy, done);
        end
        tick();
        start = 1'b0;
        @(negedge eboxClk);
        n_chk++;
        if (busy !== 1'b1 || done !== 1'b0 || ctlArLoad !== 1'b1) begin
            n_fail++; $display("FAIL abort_restart busy=%b done=%b ld=%b required 1 0 1", busy, done, ctlArLoad);
        end
        tick();
        @(negedge eboxClk);
        n_chk++;
        if (done !== 1'b1 || stepsDone !== 6'd1) begin
            n_fail++; $display("FAIL abort_restart_done done=%b steps=%0d required 1 1", done, stepsDone);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic eb, ed;
        start = 1'b1; opDiv = 1'b0; stepCount = 6'd2; mq35 = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            if (c >= 1 && c <= 3) stepCount = 6'd5;
            else stepCount = 6'd2;
            if (c == 5) start = 1'b0;
            @(negedge eboxClk);
            eb = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
            ed = (c == 3) || (c == 7);
            n_chk++;
            if (busy !== eb || done !== ed) begin
                n_fail++; $display("FAIL b2b cycle=%0d busy=%b done=%b required %b %b", c, busy, done, eb, ed);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_step();
        start_op(1'b0, 36);
        for (int c = 1; c < 10; c++) begin
            mq35 = c[0];
            tick();
        end
        @(negedge eboxClk);
        n_chk++;
        if (busy !== 1'b1 || stepsDone !== 6'd9) begin
            n_fail++; $display("FAIL rst_pre busy=%b steps=%0d required 1 9", busy, stepsDone);
        end
        #1 eboxReset_n = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || ctlMqSel !== 2'b11 || stepsDone !== '0 || ctlArLoad !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid busy=%b mq=%b steps=%0d ld=%b required 0 11 0 0",
                               busy, ctlMqSel, stepsDone, ctlArLoad);
        end
        @(negedge eboxClk);
        eboxReset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_mul_booth();
        test_div_fixup();
        test_zero_steps();
        test_random_mul();
        test_div_overflow();
        test_abort();
        test_back_to_back();
        test_reset_mid_step();
        test_mul_booth();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
